// File: rtl/debounce_edge_detect.sv
// rtl/debounce_edge_detect.sv - debounced level with rise/fall strobes
// Optional macro PRESS_COUNT_EN adds an 8-bit count of debounced rising edges.
module debounce_edge_detect #(
  parameter int STABLE_COUNT = 1000000,
  parameter int CNT_WIDTH    = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_in,
  output logic       db_level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_db_level, w_db_level_nxt;
  logic                 r_rise, w_rise_nxt;
  logic                 r_fall, w_fall_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE_LOW;
      r_cnt      <= '0;
      r_db_level <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_db_level <= w_db_level_nxt;
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
    end
  end

  // A sample of the old level while waiting drops straight back to idle,
  // so any glitch restarts qualification from zero.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_db_level_nxt = r_db_level;
    w_rise_nxt     = 1'b0;
    w_fall_nxt     = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (sync_in) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = LP_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_in) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt    = IDLE_HIGH;
          w_cnt_nxt      = '0;
          w_db_level_nxt = 1'b1;
          w_rise_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_in) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = LP_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt    = IDLE_LOW;
          w_cnt_nxt      = '0;
          w_db_level_nxt = 1'b0;
          w_fall_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      default: begin
        w_state_nxt    = IDLE_LOW;
        w_cnt_nxt      = '0;
        w_db_level_nxt = 1'b0;
      end
    endcase
  end

  assign db_level   = r_db_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef PRESS_COUNT_EN
  logic [7:0] r_press;

  // Counts on the commit edge so the new value appears alongside rise_pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_press <= 8'd0;
    end else if (w_rise_nxt) begin
      r_press <= r_press + 8'd1;
    end
  end

  assign press_count = r_press;
`else
  assign press_count = 8'd0;
`endif

endmodule

// File: doc/debounce_edge_detect.md
Name: debounce_edge_detect

Overview:
- Downstream consumer of the two-flop input synchronizer stage. Takes the already-synchronized level from a switch or button (the synchronizer's second-stage output) and filters contact bounce.
- Produces a clean debounced level plus single-cycle rise and fall strobes for the counters and FSMs in the rest of the lab design.
- Holds the output until the input has been stable for a programmable number of clock cycles.

Parameters:
- STABLE_COUNT, 1000000, consecutive cycles the input must hold a new value before the output follows (10 ms at 100 MHz). Must be >= 2.
- CNT_WIDTH, 20, width of the stability counter. Must satisfy 2^CNT_WIDTH >= STABLE_COUNT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- sync_in  input  1  synchronized raw level, from the synchronizer second stage.
- db_level  output  1  debounced level.
- rise_pulse  output  1  one-cycle strobe when db_level goes 0->1.
- fall_pulse  output  1  one-cycle strobe when db_level goes 1->0.
- press_count  output  8  count of debounced rising edges (see Optional Feature).

Behaviour:
- One clock. Reset is synchronous and active-low: sampled only on the rising edge of clk while reset_n=0.
- Reset values:
  - state=IDLE_LOW, cnt=0
  - db_level=0, rise_pulse=0, fall_pulse=0, press_count=0
- Reset has priority over every other event.
- A mid-operation reset abandons any partial count. No pulse is generated by reset itself, including when db_level was 1.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - sync_in=1 -> WAIT_HIGH, cnt<=1.
  - sync_in=0 -> stay, cnt<=0.
- WAIT_HIGH:
  - sync_in=0 -> IDLE_LOW, cnt<=0 (bounce, nothing emitted).
  - sync_in=1 and cnt==STABLE_COUNT-1 -> IDLE_HIGH, cnt<=0, db_level<=1, rise_pulse<=1.
  - otherwise cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW mirror the above with polarity inverted; the commit sets db_level<=0 and fall_pulse<=1.
- Latency:
  - db_level changes on the same clock edge as the STABLE_COUNT-th consecutive sample of the new value.
  - The strobe is high for exactly the first cycle in which db_level shows the new value.
  - All outputs are registered; no combinational path from sync_in to any output.
- rise_pulse and fall_pulse are never high together and never high for two consecutive cycles.
- cnt never exceeds STABLE_COUNT-1, so there is no counter wrap.
- A one-cycle glitch back to the old value at any point in WAIT_* restarts qualification from zero.
- Input that toggles every cycle indefinitely never changes db_level.

Optional Feature:
- Macro: PRESS_COUNT_EN.
- Defined:
  - press_count increments by 1 in the same cycle rise_pulse is asserted.
  - Wraps 255->0; fall events do not affect it.
  - Reset clears it to 0.
- Undefined:
  - Port still exists, tied to 8'd0.
  - No counter register is synthesized.

Test Plan (STABLE_COUNT=4, CNT_WIDTH=3):
- Hold reset_n=0 for 2 cycles with sync_in=1 -> db_level=0, both pulses 0, press_count=0.
- Raise sync_in at edge E and hold -> db_level=1 and rise_pulse=1 in the cycle after edge E+3 only; rise_pulse=0 the following cycle.
- Bounce pattern sync_in=1,1,1,0,1,1,1,1 -> no commit after the first three 1s; db_level rises only after the 4th consecutive 1 of the second run.
- From db_level=1, drop sync_in to 0 and hold 4 cycles -> fall_pulse one cycle, db_level=0, press_count unchanged.
- Assert reset_n=0 while in WAIT_HIGH with cnt=3 -> next cycle state IDLE_LOW, cnt=0, no rise_pulse.
- With PRESS_COUNT_EN defined, 257 clean presses -> press_count=1; without the macro -> press_count stays 0.
